// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read controller with 2-entry skid buffer and stream output
//
// Purpose:
//   Pulls words from a synchronous FIFO (one cycle read latency) and presents
//   them on a valid/ready stream through a 2-entry in-order skid buffer. The
//   buffer occupancy plus the in-flight read never exceeds two, so no word is
//   lost under backpressure. A flush discards held and in-flight words.
//
// Optional feature:
//   FIFO_RD_PARITY_EN - adds m_parity, the XOR reduction of each word,
//   computed at capture, stored alongside the word and aligned with m_data.
//
// Ports:
//   rd_clk     in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   buf_out    in   FIFO read data, valid the cycle after rd_en
//   buf_empty  in   FIFO empty flag
//   rd_en      out  FIFO read request
//   flush      in   discard held and in-flight words
//   m_data     out  stream data (head entry)
//   m_valid    out  stream valid
//   m_ready    in   stream accept
//   xfer_cnt   out  count of completed stream handshakes (wraps)
//   m_parity   out  parity of m_data (only with FIFO_RD_PARITY_EN)
//   busy       out  high while any word is held or in flight

module fifo_rd_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] buf_out,
  input  logic              buf_empty,
  output logic              rd_en,
  input  logic              flush,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  xfer_cnt,
`ifdef FIFO_RD_PARITY_EN
  output logic              m_parity,
`endif
  output logic              busy
);

  // Each entry carries the word and, when enabled, its parity bit in the MSB.
`ifdef FIFO_RD_PARITY_EN
  localparam int ENT_W = DATA_W + 1;
`else
  localparam int ENT_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic             pend_q, pend_d;
  logic [ENT_W-1:0] ent0_q, ent0_d;   // head
  logic [ENT_W-1:0] ent1_q, ent1_d;   // second-in-line
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ENT_W-1:0] cap_word;
  logic [1:0]       used;
  logic             pop;
  logic             cap;

`ifdef FIFO_RD_PARITY_EN
  assign cap_word = {^buf_out, buf_out};
`else
  assign cap_word = buf_out;
`endif

  assign m_valid = (occ_q != OCC_EMPTY);
  assign m_data  = ent0_q[DATA_W-1:0];
`ifdef FIFO_RD_PARITY_EN
  assign m_parity = ent0_q[DATA_W];
`endif
  assign busy     = m_valid || pend_q;
  assign xfer_cnt = cnt_q;

  assign used = occ_q + {1'b0, pend_q};
  assign pop  = m_valid && m_ready;
  assign cap  = pend_q && !flush;

  // A read may be issued into a full reservation when the head leaves on the
  // same edge; that is what gives one word per cycle under continuous ready.
  assign rd_en = !buf_empty && !flush && rst_n && ((used < 2'd2) || pop);

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      pend_q <= 1'b0;
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= pend_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    pend_d = rd_en;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;

    if (pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (cap) begin
            ent0_d = cap_word;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Capture and pop together: the new word becomes the head directly.
          if (cap && pop) begin
            ent0_d = cap_word;
          end else if (cap) begin
            ent1_d = cap_word;
            occ_d  = OCC_TWO;
          end else if (pop) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Full: the second entry shifts to the head; a simultaneous capture
          // refills the second slot. Capture without pop cannot occur here.
          if (pop) begin
            ent0_d = ent1_q;
            if (cap) begin
              ent1_d = cap_word;
            end else begin
              occ_d = OCC_ONE;
            end
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl

module tb_fifo_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rst_n;
  logic [7:0] buf_out;
  logic       buf_empty;
  logic       rd_en;
  logic       flush;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] xfer_cnt;
  logic       busy;
`ifdef FIFO_RD_PARITY_EN
  logic       m_parity;
`endif

  fifo_rd_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .buf_out   (buf_out),
    .buf_empty (buf_empty),
    .rd_en     (rd_en),
    .flush     (flush),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .xfer_cnt  (xfer_cnt),
`ifdef FIFO_RD_PARITY_EN
    .m_parity  (m_parity),
`endif
    .busy      (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: upstream FIFO contents, words held downstream-side,
  // whether a read is in flight, and the handshake count.
  logic [7:0] src[$];
  logic [7:0] held[$];
  logic [7:0] got[$];
  int         rq[$];
  int         vq[$];
  logic       pend_m = 1'b0;
  logic [3:0] cnt_m  = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    src.push_back(w);
    buf_empty = 1'b0;
  endtask

  // One clock cycle: called just after a falling edge with inputs applied.
  task automatic cycle();
    logic exp_rd;
    logic hs;
    #1;
    exp_rd = (src.size() > 0) && !flush &&
             ((held.size() + int'(pend_m) < 2) || (held.size() > 0 && m_ready));
    hs = (held.size() > 0) && m_ready;
    chk("rd_en", rd_en, exp_rd);
    chk("m_valid", m_valid, held.size() > 0);
    if (held.size() > 0) begin
      chk("m_data", m_data, held[0]);
`ifdef FIFO_RD_PARITY_EN
      chk("m_parity", m_parity, ^held[0]);
`endif
    end
    chk("xfer_cnt", xfer_cnt, cnt_m);
    chk("busy", busy, (held.size() > 0) || pend_m);
    if (rd_en) rq.push_back(cyc);
    if (m_valid) vq.push_back(cyc);
    @(posedge rd_clk);
    if (hs) begin
      got.push_back(held[0]);
      cnt_m = cnt_m + 4'd1;
      void'(held.pop_front());
    end
    if (flush) begin
      held.delete();
      pend_m = 1'b0;
    end else begin
      if (pend_m) held.push_back(buf_out);
      pend_m = exp_rd;
    end
    #1;
    if (exp_rd) buf_out = src.pop_front();
    buf_empty = (src.size() == 0);
    cyc++;
    @(negedge rd_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((held.size() > 0 || pend_m || src.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", n < budget, 1'b1);
  endtask

  task automatic rst_check();
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_xfer_cnt", xfer_cnt, 4'h0);
    chk("rst_busy", busy, 1'b0);
`ifdef FIFO_RD_PARITY_EN
    chk("rst_m_parity", m_parity, 1'b0);
`endif
  endtask

  // Asserted between edges so the check proves the reset is asynchronous.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    rst_check();
    held.delete();
    pend_m = 1'b0;
    cnt_m  = 4'd0;
    @(negedge rd_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] cnt_hold;
    int         ng;
    int         lat;

    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; buf_out = 8'h00;
    buf_empty = 1'b0;               // rd_en must still be held low in reset
    #3;
    rst_check();
    buf_empty = 1'b1;
    @(negedge rd_clk);
    @(negedge rd_clk);
    rst_n = 1'b1;

    // Empty boundary, then a single word and its latency.
    m_ready = 1'b1;
    run(4);
    rq.delete(); vq.delete(); got.delete();
    push(8'hE5);
    run(6);
    chk("e5_rd_pulses", rq.size(), 1);
    lat = (rq.size() > 0 && vq.size() > 0) ? vq[0] - rq[0] : -1;
    chk("e5_latency", lat, 2);
    chk("e5_word", got.size() > 0 ? got[0] : 8'hXX, 8'hE5);

    // In-order drain at one word per cycle.
    got.delete(); vq.delete();
    cnt_hold = cnt_m;
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    run_idle(20);
    chk("drain_count", got.size(), 4);
    chk("drain_words", {got[0], got[1], got[2], got[3]}, 32'hA1B2C3D4);
    chk("drain_back_to_back", (vq.size() == 4) ? vq[3] - vq[0] : -1, 3);
    chk("drain_xfer", xfer_cnt, cnt_hold + 4'd4);
    chk("drain_busy", busy, 1'b0);

    // Backpressure: holds two, stops reading, head stays put.
    got.delete();
    m_ready = 1'b0;
    push(8'hA1); push(8'hB2); push(8'hC3);
    run(5);
    #1;
    chk("bp_rd_en", rd_en, 1'b0);
    chk("bp_head", m_data, 8'hA1);
    chk("bp_busy", busy, 1'b1);
    @(negedge rd_clk);
    m_ready = 1'b1;
    run_idle(20);
    chk("bp_words", {got.size() == 3, got[0], got[1], got[2]}, {1'b1, 24'hA1B2C3});

    // Flush while one word held and one in flight.
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    run(3);
    m_ready = 1'b0; flush = 1'b1;
    src.delete(); buf_empty = 1'b1;
    cnt_hold = cnt_m; ng = got.size();
    cycle();
    flush = 1'b0; m_ready = 1'b1;
    #1;
    chk("flush1_m_valid", m_valid, 1'b0);
    @(negedge rd_clk);
    run(3);
    chk("flush1_xfer", xfer_cnt, cnt_hold);
    chk("flush1_no_output", got.size(), ng);

    // Flush with both entries held.
    m_ready = 1'b0;
    push(8'h20); push(8'h21); push(8'h22);
    run(4);
    flush = 1'b1;
    src.delete(); buf_empty = 1'b1;
    cnt_hold = cnt_m; ng = got.size();
    cycle();
    flush = 1'b0; m_ready = 1'b1;
    run(3);
    chk("flush2_xfer", xfer_cnt, cnt_hold);
    chk("flush2_no_output", got.size(), ng);
    chk("flush2_busy", busy, 1'b0);

    // Reset mid-stream, then 17 handshakes wrap the 4-bit counter to 1.
    m_ready = 1'b0;
    push(8'h31); push(8'h32); push(8'h33);
    run(3);
    mid_reset();
    src.delete(); buf_empty = 1'b1;
    run(2);
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
    m_ready = 1'b1;
    run_idle(40);
    chk("wrap_xfer", xfer_cnt, 4'd1);

    // Reset release with data waiting: read issued on first edge.
    m_ready = 1'b0;
    push(8'h55); push(8'h66); push(8'h77);
    run(2);
    mid_reset();
    run(2);
    m_ready = 1'b1;
    run_idle(20);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) != 0 && src.size() < 8) push(8'($urandom));
      cycle();
    end
    flush = 1'b0; m_ready = 1'b1;
    run_idle(40);
    chk("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
